// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-pipeline sequencer: NOP default,
// stage-index width helper and the per-edge action codes.
package pipeline_pkg;

  localparam logic [7:0] NOP_OPCODE_DEFAULT = 8'h00;

  // Per-edge action, listed in priority order (highest first).
  localparam int unsigned ACT_W = 3;
  typedef logic [ACT_W-1:0] action_t;

  localparam action_t ACT_RESET       = 3'd0;
  localparam action_t ACT_HOLD_HALTED = 3'd1;
  localparam action_t ACT_HALT        = 3'd2;
  localparam action_t ACT_CANCEL      = 3'd3;
  localparam action_t ACT_STALL       = 3'd4;
  localparam action_t ACT_ADVANCE     = 3'd5;

  // Bits needed to index a stage; never less than one.
  function automatic int unsigned stage_idx_w(input int unsigned stages);
    int unsigned w;
    w = 1;
    if (stages > 32'd2) w = 32'($clog2(stages));
    return w;
  endfunction

endpackage

// File: rtl/pipeline_slot.sv
// One pipeline stage: instruction plus valid bit with load/hold/clear.
// Invalid contents are always forced to the NOP opcode.
module pipeline_slot #(
  parameter int unsigned         INSTR_W    = 8,
  parameter logic [INSTR_W-1:0]  NOP_OPCODE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic               d_valid,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  // Priority: reset > clear > load > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= NOP_OPCODE;
      valid <= 1'b0;
    end else if (clear) begin
      instr <= NOP_OPCODE;
      valid <= 1'b0;
    end else if (load) begin
      instr <= d_valid ? d_instr : NOP_OPCODE;
      valid <= d_valid;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Parametrised instruction-pipeline sequencer: STAGES slots with flush,
// global stall, sticky halt and cycle/retire counters.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned        STAGES     = 2,
  parameter int unsigned        INSTR_W    = 8,
  parameter logic [INSTR_W-1:0] NOP_OPCODE = INSTR_W'(NOP_OPCODE_DEFAULT),
  parameter int unsigned        CNT_W      = 16
) (
  input  logic                      CLK,
  input  logic                      RST_bar,
  input  logic [INSTR_W-1:0]        INSTR_IN,
  input  logic                      INSTR_VALID,
  input  logic                      STALL,
  input  logic                      CANCEL,
  input  logic                      HALT_REQ,
  output logic [STAGES*INSTR_W-1:0] STAGE_INSTR,
  output logic [STAGES-1:0]         STAGE_VALID,
  output logic                      FETCH_ADVANCE,
  output logic                      HALT,
  output logic [CNT_W-1:0]          CYCLE_COUNT,
  output logic [CNT_W-1:0]          RETIRE_COUNT
);

  localparam int unsigned       IDX_W = stage_idx_w(STAGES);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(STAGES - 1);

  action_t           action;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] clear;
  logic              retire;
  logic              last_valid;

  assign last_valid = STAGE_VALID[LAST];

  // Priority-encoded action for this edge.
  always_comb begin
    action = ACT_ADVANCE;
    if (!RST_bar)                   action = ACT_RESET;
    else if (HALT)                  action = ACT_HOLD_HALTED;
    else if (HALT_REQ & last_valid) action = ACT_HALT;
    else if (CANCEL)                action = ACT_CANCEL;
    else if (STALL)                 action = ACT_STALL;
  end

  // Slot controls, retire strobe and fetch handshake derived from the action.
  always_comb begin
    load          = '0;
    clear         = '0;
    retire        = 1'b0;
    FETCH_ADVANCE = 1'b0;
    case (action)
      ACT_HALT: begin
        clear[LAST] = 1'b1;
        retire      = 1'b1;
      end
      ACT_CANCEL: begin
        clear  = '1;
        retire = last_valid;
      end
      ACT_ADVANCE: begin
        load          = '1;
        retire        = last_valid;
        FETCH_ADVANCE = INSTR_VALID;
      end
      default: ;
    endcase
  end

  // Sticky halt and counters; everything freezes once halted.
  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      HALT         <= 1'b0;
      CYCLE_COUNT  <= '0;
      RETIRE_COUNT <= '0;
    end else if (!HALT) begin
      CYCLE_COUNT <= CYCLE_COUNT + CNT_W'(1);
      if (retire) RETIRE_COUNT <= RETIRE_COUNT + CNT_W'(1);
      if (action == ACT_HALT) HALT <= 1'b1;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic [INSTR_W-1:0] d_instr;
    logic               d_valid;

    if (k == 0) begin : g_head
      assign d_instr = INSTR_IN;
      assign d_valid = INSTR_VALID;
    end else begin : g_body
      assign d_instr = STAGE_INSTR[(k-1)*INSTR_W +: INSTR_W];
      assign d_valid = STAGE_VALID[k-1];
    end

    pipeline_slot #(
      .INSTR_W   (INSTR_W),
      .NOP_OPCODE(NOP_OPCODE)
    ) u_slot (
      .clk    (CLK),
      .rst_n  (RST_bar),
      .load   (load[k]),
      .clear  (clear[k]),
      .d_instr(d_instr),
      .d_valid(d_valid),
      .instr  (STAGE_INSTR[k*INSTR_W +: INSTR_W]),
      .valid  (STAGE_VALID[k])
    );
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: a 2-stage and a 4-stage/4-bit-counter instance
// share one stimulus stream and are checked against an array-based model.
module tb_pipeline_sequencer;

  logic        CLK;
  logic        RST_bar;
  logic [7:0]  INSTR_IN;
  logic        INSTR_VALID;
  logic        STALL;
  logic        CANCEL;
  logic        HALT_REQ;

  logic [15:0] s2_instr;
  logic [1:0]  s2_valid;
  logic        s2_fetch;
  logic        s2_halt;
  logic [15:0] s2_cyc;
  logic [15:0] s2_ret;

  logic [31:0] s4_instr;
  logic [3:0]  s4_valid;
  logic        s4_fetch;
  logic        s4_halt;
  logic [3:0]  s4_cyc;
  logic [3:0]  s4_ret;

  int checks = 0;
  int errors = 0;

  pipeline_sequencer #(.STAGES(2), .INSTR_W(8), .NOP_OPCODE(8'h00), .CNT_W(16)) dut2 (
    .CLK(CLK), .RST_bar(RST_bar), .INSTR_IN(INSTR_IN), .INSTR_VALID(INSTR_VALID),
    .STALL(STALL), .CANCEL(CANCEL), .HALT_REQ(HALT_REQ),
    .STAGE_INSTR(s2_instr), .STAGE_VALID(s2_valid), .FETCH_ADVANCE(s2_fetch),
    .HALT(s2_halt), .CYCLE_COUNT(s2_cyc), .RETIRE_COUNT(s2_ret)
  );

  pipeline_sequencer #(.STAGES(4), .INSTR_W(8), .NOP_OPCODE(8'h00), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST_bar(RST_bar), .INSTR_IN(INSTR_IN), .INSTR_VALID(INSTR_VALID),
    .STALL(STALL), .CANCEL(CANCEL), .HALT_REQ(HALT_REQ),
    .STAGE_INSTR(s4_instr), .STAGE_VALID(s4_valid), .FETCH_ADVANCE(s4_fetch),
    .HALT(s4_halt), .CYCLE_COUNT(s4_cyc), .RETIRE_COUNT(s4_ret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: m=0 is the 2-stage instance, m=1 the 4-stage one. Counters are
  // unbounded here and reduced modulo 2^CNT_W only when compared.
  int          nstages [2] = '{2, 4};
  int          cnt_w   [2] = '{16, 4};
  logic [7:0]  m_instr [2][4];
  bit          m_valid [2][4];
  bit          m_halt  [2];
  int unsigned m_cyc   [2];
  int unsigned m_ret   [2];
  bit          model_ok = 1'b0;

  task automatic model_step(input int m);
    int s;
    s = nstages[m];
    if (!RST_bar) begin
      for (int k = 0; k < 4; k++) begin
        m_instr[m][k] = 8'h00;
        m_valid[m][k] = 1'b0;
      end
      m_halt[m] = 1'b0;
      m_cyc[m]  = 0;
      m_ret[m]  = 0;
    end else if (!m_halt[m]) begin
      m_cyc[m]++;
      if (HALT_REQ && m_valid[m][s-1]) begin
        m_ret[m]++;
        m_valid[m][s-1] = 1'b0;
        m_instr[m][s-1] = 8'h00;
        m_halt[m] = 1'b1;
      end else if (CANCEL) begin
        if (m_valid[m][s-1]) m_ret[m]++;
        for (int k = 0; k < s; k++) begin
          m_instr[m][k] = 8'h00;
          m_valid[m][k] = 1'b0;
        end
      end else if (!STALL) begin
        if (m_valid[m][s-1]) m_ret[m]++;
        for (int k = s - 1; k > 0; k--) begin
          m_instr[m][k] = m_instr[m][k-1];
          m_valid[m][k] = m_valid[m][k-1];
        end
        m_instr[m][0] = INSTR_VALID ? INSTR_IN : 8'h00;
        m_valid[m][0] = INSTR_VALID;
      end
    end
  endtask

  always @(posedge CLK) begin
    for (int m = 0; m < 2; m++) model_step(m);
    if (!RST_bar) model_ok = 1'b1;
  end

  function automatic logic [31:0] exp_instr(input int m);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nstages[m]; k++) v[k*8 +: 8] = m_instr[m][k];
    return v;
  endfunction

  function automatic logic [3:0] exp_valid(input int m);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < nstages[m]; k++) v[k] = m_valid[m][k];
    return v;
  endfunction

  function automatic logic exp_fetch(input int m);
    return RST_bar && !m_halt[m] && !STALL && !CANCEL &&
           !(HALT_REQ && m_valid[m][nstages[m]-1]) && INSTR_VALID;
  endfunction

  function automatic logic [63:0] wrap(input int unsigned v, input int w);
    return 64'(v % (32'd1 << w));
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (model_ok) begin
      check("d2_instr",  64'(s2_instr), 64'(exp_instr(0)));
      check("d2_valid",  64'(s2_valid), 64'(exp_valid(0)));
      check("d2_fetch",  64'(s2_fetch), 64'(exp_fetch(0)));
      check("d2_halt",   64'(s2_halt),  64'(m_halt[0]));
      check("d2_cycle",  64'(s2_cyc),   wrap(m_cyc[0], cnt_w[0]));
      check("d2_retire", 64'(s2_ret),   wrap(m_ret[0], cnt_w[0]));
      check("d4_instr",  64'(s4_instr), 64'(exp_instr(1)));
      check("d4_valid",  64'(s4_valid), 64'(exp_valid(1)));
      check("d4_fetch",  64'(s4_fetch), 64'(exp_fetch(1)));
      check("d4_halt",   64'(s4_halt),  64'(m_halt[1]));
      check("d4_cycle",  64'(s4_cyc),   wrap(m_cyc[1], cnt_w[1]));
      check("d4_retire", 64'(s4_ret),   wrap(m_ret[1], cnt_w[1]));
    end
  end

  task automatic drive(input logic rst, input logic iv, input logic [7:0] din,
                       input logic stall, input logic cancel, input logic hreq);
    RST_bar     = rst;
    INSTR_VALID = iv;
    INSTR_IN    = din;
    STALL       = stall;
    CANCEL      = cancel;
    HALT_REQ    = hreq;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_instr",  64'(s2_instr), 64'h0);
    check("rst_valid",  64'(s2_valid), 64'h0);
    check("rst_halt",   64'(s2_halt),  64'h0);
    check("rst_cycle",  64'(s2_cyc),   64'h0);
    check("rst_retire", 64'(s2_ret),   64'h0);

    // Fill: 0x11, 0x22, 0x33.
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    #1 check("fill_fetch", 64'(s2_fetch), 64'h1);
    tick();
    check("e1_instr", 64'(s2_instr), 64'h0011);
    check("e1_valid", 64'(s2_valid), 64'h1);
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check("e2_instr", 64'(s2_instr), 64'h1122);
    check("e2_valid", 64'(s2_valid), 64'h3);
    drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    tick();
    check("e3_instr",  64'(s2_instr), 64'h2233);
    check("e3_retire", 64'(s2_ret),   64'd1);
    check("e3_cycle",  64'(s2_cyc),   64'd3);

    // Stall for three edges.
    drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    #1 check("stall_fetch", 64'(s2_fetch), 64'h0);
    for (int i = 0; i < 3; i++) tick();
    check("stall_instr",  64'(s2_instr), 64'h2233);
    check("stall_retire", 64'(s2_ret),   64'd1);
    check("stall_cycle",  64'(s2_cyc),   64'd6);

    // Cancel while stalled: full flush, last-stage 0x22 retires.
    drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    #1 check("cancel_fetch", 64'(s2_fetch), 64'h0);
    tick();
    check("cancel_instr",  64'(s2_instr), 64'h0);
    check("cancel_valid",  64'(s2_valid), 64'h0);
    check("cancel_retire", 64'(s2_ret),   64'd2);
    check("cancel_cycle",  64'(s2_cyc),   64'd7);

    // Refill, then halt request with cancel and stall also high.
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    #1 check("halt_fetch", 64'(s2_fetch), 64'h0);
    tick();
    check("halt_flag",   64'(s2_halt),  64'h1);
    check("halt_retire", 64'(s2_ret),   64'd3);
    check("halt_cycle",  64'(s2_cyc),   64'd10);
    check("halt_instr",  64'(s2_instr), 64'h0066);
    check("halt_valid",  64'(s2_valid), 64'h1);

    // Halted: random inputs must change nothing.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check("frozen_halt",   64'(s2_halt),  64'h1);
    check("frozen_retire", 64'(s2_ret),   64'd3);
    check("frozen_cycle",  64'(s2_cyc),   64'd10);
    check("frozen_instr",  64'(s2_instr), 64'h0066);

    // Reset wins over cancel and halt request.
    drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    tick();
    check("rst2_halt",   64'(s2_halt),  64'h0);
    check("rst2_valid",  64'(s2_valid), 64'h0);
    check("rst2_instr",  64'(s2_instr), 64'h0);
    check("rst2_cycle",  64'(s2_cyc),   64'h0);
    check("rst2_retire", 64'(s2_ret),   64'h0);
    check("rst2_d4",     64'(s4_valid), 64'h0);

    // Continuous stream of 1..20; halt request on edge 1 hits an empty last stage.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, (i == 1) ? 1'b1 : 1'b0);
      tick();
      if (i == 1)  check("hreq_ignored", 64'(s2_halt), 64'h0);
      if (i == 19) check("d4_ret_e19",   64'(s4_ret),  64'd15);
    end
    check("d4_ret_wrap", 64'(s4_ret),   64'd0);
    check("d4_cyc_e20",  64'(s4_cyc),   64'd4);
    check("d4_instr_e20", 64'(s4_instr), 64'h11121314);
    check("d2_ret_e20",  64'(s2_ret),   64'd18);
    check("d2_cyc_e20",  64'(s2_cyc),   64'd20);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
